// File: rtl/data_mem_responder.sv
// Responder end of the core load/store interface: one outstanding request over valid/ready,
// RV32I byte/half/word access to an on-chip RAM, response after a fixed LATENCY.
module data_mem_responder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int unsigned IDX_W  = ADDR_BITS - 2;
  localparam int unsigned WORDS  = 1 << IDX_W;
  localparam int unsigned LANES  = WIDTH / 8;
  localparam int unsigned CNT_W  = 4;
  localparam bit          DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               writeQ;
  logic [2:0]         funct3Q;
  logic [WIDTH-1:0]   addrQ;
  logic [WIDTH-1:0]   wdataQ;
  logic [WIDTH-1:0]   mem [WORDS];

  logic               accept;
  logic               doAccess;
  logic               accWrite;
  logic [2:0]         accF3;
  logic [WIDTH-1:0]   accAddr;
  logic [WIDTH-1:0]   accWdata;
  logic [IDX_W-1:0]   wordIdx;
  logic [4:0]         laneShift;
  logic [4:0]         halfShift;
  logic [WIDTH-1:0]   memWord;
  logic [WIDTH-1:0]   byteShifted;
  logic [WIDTH-1:0]   halfShifted;
  logic [WIDTH-1:0]   wAligned;
  logic [LANES-1:0]   byteEn;
  logic               accErr;
  logic [WIDTH-1:0]   loadData;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the access happens on the accept edge, straight from the request bus.
  assign accWrite = DIRECT ? req_write  : writeQ;
  assign accF3    = DIRECT ? req_funct3 : funct3Q;
  assign accAddr  = DIRECT ? req_addr   : addrQ;
  assign accWdata = DIRECT ? req_wdata  : wdataQ;
  assign doAccess = DIRECT ? accept : ((state == BUSY) && (count == CNT_W'(1)));

  assign wordIdx     = accAddr[ADDR_BITS-1:2];
  assign laneShift   = {accAddr[1:0], 3'b000};
  assign halfShift   = {accAddr[1], 4'b0000};
  assign memWord     = mem[wordIdx];
  assign byteShifted = memWord >> laneShift;
  assign halfShifted = memWord >> halfShift;
  assign wAligned    = accWdata << laneShift;

  always_comb begin
    accErr = 1'b0;
    if (accWrite) begin
      if (!(accF3 inside {3'b000, 3'b001, 3'b010})) accErr = 1'b1;
    end else begin
      if (!(accF3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) accErr = 1'b1;
    end
    if ((accF3[1:0] == 2'b01) && accAddr[0]) accErr = 1'b1;
    if ((accF3[1:0] == 2'b10) && (accAddr[1:0] != 2'b00)) accErr = 1'b1;
    if (accAddr[WIDTH-1:ADDR_BITS] != '0) accErr = 1'b1;
  end

  always_comb begin
    loadData = '0;
    byteEn   = '1;
    case (accF3[1:0])
      2'b00:   byteEn = LANES'(1) << accAddr[1:0];
      2'b01:   byteEn = LANES'(3) << accAddr[1:0];
      default: byteEn = '1;
    endcase
    if (!accWrite && !accErr) begin
      case (accF3)
        3'b000:  loadData = {{(WIDTH-8){byteShifted[7]}}, byteShifted[7:0]};
        3'b100:  loadData = {{(WIDTH-8){1'b0}}, byteShifted[7:0]};
        3'b001:  loadData = {{(WIDTH-16){halfShifted[15]}}, halfShifted[15:0]};
        3'b101:  loadData = {{(WIDTH-16){1'b0}}, halfShifted[15:0]};
        default: loadData = memWord;
      endcase
    end
  end

  // RAM is not reset; a store only lands on its access edge, never while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && doAccess && accWrite && !accErr) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (byteEn[i]) mem[wordIdx][i*8 +: 8] <= wAligned[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      writeQ     <= 1'b0;
      funct3Q    <= '0;
      addrQ      <= '0;
      wdataQ     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            writeQ  <= req_write;
            funct3Q <= req_funct3;
            addrQ   <= req_addr;
            wdataQ  <= req_wdata;
            if (DIRECT) begin
              resp_valid <= 1'b1;
              resp_rdata <= loadData;
              resp_err   <= accErr;
              state      <= RESP;
            end else begin
              count <= CNT_W'(LATENCY - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          count <= count - CNT_W'(1);
          if (doAccess) begin
            resp_valid <= 1'b1;
            resp_rdata <= loadData;
            resp_err   <= accErr;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
